// File: rtl/ccff_pkg.sv
// Shared constants and FSM encoding for the configuration-chain loader.
package ccff_pkg;

  localparam int CCFF_WORD_W = 8;
  localparam int CCFF_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ccff_serializer.sv
// Single-word buffer that presents one bitstream word to the chain, LSB first.
module ccff_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              shift,
  input  logic              flush,
  output logic              buf_valid,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_buf;
  logic [IDX_W-1:0]  bit_idx;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      word_buf  <= '0;
      buf_valid <= 1'b0;
      bit_idx   <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
      bit_idx   <= '0;
    end else if (load) begin
      // A load on the last shifted bit refills the buffer with no bubble.
      word_buf  <= data;
      buf_valid <= 1'b1;
      bit_idx   <= '0;
    end else if (shift) begin
      if (last_bit) begin
        buf_valid <= 1'b0;
        bit_idx   <= '0;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign bit_out  = word_buf[bit_idx];
  assign last_bit = (bit_idx == LAST_IDX);

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams bitstream words into the chain head, or
// recirculates the chain and compares it against the stream in verify mode.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W,
  parameter int LEN_W  = CCFF_LEN_W
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  err_count
);

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] ERR_MAX = '1;

  state_t           state, state_nxt;
  logic             mode;
  logic [LEN_W-1:0] bits_rem;
  logic             buf_valid, bit_out, last_bit;
  logic             accept, last_shift, flush, mismatch;

  assign ccff_shift_en = (state == ST_SHIFT) && buf_valid;
  assign last_shift    = ccff_shift_en && (bits_rem == ONE);
  // Request a word only while the chain still needs bits beyond the buffered ones.
  assign s_ready       = (state == ST_SHIFT) && !abort &&
                         ((!buf_valid && bits_rem != '0) ||
                          (ccff_shift_en && last_bit && bits_rem > ONE));
  assign accept        = s_valid && s_ready;
  assign flush         = abort || last_shift;
  assign ccff_head     = ccff_shift_en && (mode ? ccff_tail : bit_out);
  assign mismatch      = ccff_shift_en && mode && (ccff_tail != bit_out);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

  ccff_serializer #(.WORD_W(WORD_W)) u_serializer (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .load       (accept),
    .data       (s_data),
    .shift      (ccff_shift_en),
    .flush      (flush),
    .buf_valid  (buf_valid),
    .bit_out    (bit_out),
    .last_bit   (last_bit)
  );

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // NOTE: next-state gets its default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = (chain_len == '0) ? ST_DONE : ST_SHIFT;
        ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      mode      <= 1'b0;
      bits_rem  <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else if (abort) begin
      bits_rem <= '0;
    end else if (state == ST_IDLE && start) begin
      mode      <= verify;
      bits_rem  <= chain_len;
      err       <= 1'b0;
      err_count <= '0;
    end else if (ccff_shift_en) begin
      bits_rem <= bits_rem - ONE;
      if (mismatch) begin
        err <= 1'b1;
        if (err_count != ERR_MAX) err_count <= err_count + ONE;
      end
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a behavioural chain plus a stream-level model of the
// expected head bits, word counts, done timing and verify mismatch counts.
module tb_ccff_loader;

  logic        prog_clk   = 1'b0;
  logic        prog_rst_n = 1'b0;
  logic        start      = 1'b0;
  logic        verify     = 1'b0;
  logic        abort      = 1'b0;
  logic        s_valid    = 1'b0;
  logic [15:0] chain_len  = '0;
  logic [7:0]  s_data     = '0;
  logic        s_ready, ccff_head, ccff_tail, ccff_shift_en, busy, done, err;
  logic [15:0] err_count;

  ccff_loader #(.WORD_W(8), .LEN_W(16)) dut (
    .prog_clk      (prog_clk),
    .prog_rst_n    (prog_rst_n),
    .start         (start),
    .verify        (verify),
    .chain_len     (chain_len),
    .abort         (abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_count     (err_count)
  );

  initial forever #5 prog_clk = ~prog_clk;

  // Chain model: bit 0 is nearest the head, tail is bit chain_l-1.
  logic [63:0] chain   = '0;
  int          chain_l = 14;
  assign ccff_tail = chain[6'(chain_l - 1)];
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[62:0], ccff_head};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0]  feed_q[$];
  logic        exp_bits[$];
  bit          op_active = 1'b0;

  // Observations collected by the compare process.
  int          cyc = 0, shift_n = 0, words_acc = 0;
  int          first_sh = -1, last_sh = -1, last_evt = 0, done_gap = -1;
  bit          m_mode = 1'b0;
  int          m_len = 0;
  logic [63:0] head_log = '0;

  function automatic logic [63:0] chain_mask(input int len);
    return (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
  endfunction

  // After a load of L bits, stream bit k sits at chain position L-1-k.
  function automatic logic [63:0] stream_chain(input int len);
    logic [63:0] v = '0;
    for (int k = 0; k < len; k++) v[len-1-k] = exp_bits[k];
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge prog_clk);
      cyc++;
      if (!prog_rst_n || !op_active) begin
        check("idle_shift_en", ccff_shift_en, 0);
        check("idle_s_ready", s_ready, 0);
        check("idle_done", done, 0);
        check("idle_head", ccff_head, 0);
        check("idle_busy", busy, 0);
      end else begin
        if (start) begin
          m_mode = verify; m_len = int'(chain_len);
          shift_n = 0; words_acc = 0; head_log = '0;
          first_sh = -1; last_sh = -1; last_evt = cyc; done_gap = -1;
        end
        if (!ccff_shift_en) begin
          check("head_gated", ccff_head, 0);
        end else begin
          check("busy_in_shift", busy, 1);
          check("shift_bound", shift_n < m_len, 1);
          if (shift_n < m_len) begin
            check("head_bit", ccff_head, m_mode ? ccff_tail : exp_bits[shift_n]);
            head_log[shift_n] = ccff_head;
          end
          if (first_sh < 0) first_sh = cyc;
          last_sh  = cyc;
          last_evt = cyc;
          shift_n++;
        end
        if (s_valid && s_ready) begin
          words_acc++;
          check("word_bound", words_acc <= (m_len + 7) / 8, 1);
        end
        if (done) begin
          done_gap = cyc - last_evt;
          check("busy_in_done", busy, 1);
        end
      end
    end
  end

  // One operation; stop_at >= 0 aborts (or resets, if use_rst) after that many shifts.
  task automatic run_op(input bit vmode, input int len, input int pct, input int gap_at,
                        input int gap_len, input int stop_at, input bit use_rst,
                        input int exp_err);
    int wi, sh;
    bit fin, acc, stopped;
    exp_bits.delete();
    for (int k = 0; k < len; k++) exp_bits.push_back(feed_q[k/8][k%8]);
    if (len > 0) chain_l = len;
    op_active = 1'b1;
    start = 1'b1; verify = vmode; chain_len = 16'(len);
    @(posedge prog_clk); #1;
    start = 1'b0;
    wi = 0; sh = 0; fin = 1'b0; stopped = 1'b0;
    for (int it = 0; it < 400 && !fin; it++) begin
      s_valid = (wi < feed_q.size()) && !(it >= gap_at && it < gap_at + gap_len) &&
                ($urandom_range(99) < pct);
      s_data  = (wi < feed_q.size()) ? feed_q[wi] : 8'h00;
      @(negedge prog_clk);
      acc = s_valid && s_ready;
      if (ccff_shift_en) sh++;
      if (done) fin = 1'b1;
      @(posedge prog_clk); #1;
      if (acc) wi++;
      if (!fin && stop_at >= 0 && sh >= stop_at) begin
        s_valid = 1'b0;
        stopped = 1'b1;
        fin     = 1'b1;
        if (use_rst) begin
          prog_rst_n = 1'b0;
          op_active  = 1'b0;
          #1;
          check("rst_shift_en", ccff_shift_en, 0);
          check("rst_busy", busy, 0);
          check("rst_s_ready", s_ready, 0);
          check("rst_head", ccff_head, 0);
          @(posedge prog_clk); #1;
          @(posedge prog_clk); #1;
          prog_rst_n = 1'b1;
        end else begin
          abort = 1'b1;
          @(negedge prog_clk);
          check("abort_no_done", done, 0);
          @(posedge prog_clk); #1;
          abort     = 1'b0;
          op_active = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
    if (!stopped) begin
      check("done_seen", fin, 1);
      check("shift_count", shift_n, len);
      check("words_accepted", words_acc, (len + 7) / 8);
      check("done_latency", done_gap, 1);
      check("err_flag", err, exp_err != 0);
      check("err_count", err_count, exp_err);
      if (!vmode) check("chain_after_load", chain & chain_mask(len), stream_chain(len));
    end
    op_active = 1'b0;
  endtask

  logic [63:0] snap;
  logic        load_bits[$];
  int          len, nw, nd, k;

  initial begin
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_err_count", err_count, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_shift_en", ccff_shift_en, 0);
    check("reset_head", ccff_head, 0);
    @(posedge prog_clk); @(posedge prog_clk); #1;
    prog_rst_n = 1'b1;
    @(posedge prog_clk); #1;

    // Load 0xA5, 0x3C into a 14-bit chain; a spare word must stay unread.
    feed_q = '{8'hA5, 8'h3C, 8'hFF};
    run_op(1'b0, 14, 100, -1, 0, -1, 1'b0, 0);
    check("load_head_seq", head_log[13:0], 14'h3CA5);
    check("load_span", last_sh - first_sh + 1, 14);
    check("load_words", words_acc, 2);

    snap = chain & chain_mask(14);
    run_op(1'b1, 14, 100, -1, 0, -1, 1'b0, 0);
    check("verify_chain_kept", chain & chain_mask(14), snap);
    check("verify_clean_count", err_count, 0);

    feed_q = '{8'hA5, 8'h3D, 8'hFF};
    run_op(1'b1, 14, 100, -1, 0, -1, 1'b0, 1);
    check("verify_bad_err", err, 1);
    check("verify_bad_count", err_count, 1);
    check("verify_bad_chain_kept", chain & chain_mask(14), snap);

    // Five-cycle stream stall exactly where the second word is due.
    feed_q = '{8'hA5, 8'h3C, 8'hFF};
    run_op(1'b0, 14, 100, 8, 5, -1, 1'b0, 0);
    check("stall_head_seq", head_log[13:0], 14'h3CA5);
    check("stall_span", last_sh - first_sh + 1, 19);

    run_op(1'b0, 0, 100, -1, 0, -1, 1'b0, 0);
    check("zero_len_shifts", shift_n, 0);

    // Abort a verify whose first word differs in bit 0: count must hold at 1.
    feed_q = '{8'hA4, 8'h3C, 8'hFF};
    run_op(1'b1, 14, 100, -1, 0, 6, 1'b0, 0);
    check("abort_err_held", err, 1);
    check("abort_count_held", err_count, 1);
    check("abort_busy", busy, 0);
    feed_q = '{8'hA5, 8'h3C, 8'hFF};
    run_op(1'b0, 14, 100, -1, 0, -1, 1'b0, 0);
    check("post_abort_head_seq", head_log[13:0], 14'h3CA5);

    run_op(1'b0, 14, 100, -1, 0, 6, 1'b1, 0);
    run_op(1'b0, 14, 100, -1, 0, -1, 1'b0, 0);
    check("post_reset_head_seq", head_log[13:0], 14'h3CA5);

    // Random lengths, words and stalls; verify with an occasional flipped bit,
    // which counts only when it falls inside the chain length.
    for (int r = 0; r < 12; r++) begin
      len = int'($urandom_range(40, 1));
      nw  = (len + 7) / 8;
      feed_q.delete();
      for (int i = 0; i <= nw; i++) feed_q.push_back(8'($urandom));
      run_op(1'b0, len, int'($urandom_range(100, 40)), -1, 0, -1, 1'b0, 0);
      snap = chain & chain_mask(len);
      load_bits = exp_bits;
      if ($urandom_range(1) == 1) begin
        k = int'($urandom_range(nw * 8 - 1, 0));
        feed_q[k/8][k%8] = ~feed_q[k/8][k%8];
      end
      nd = 0;
      for (int b = 0; b < len; b++) if (feed_q[b/8][b%8] != load_bits[b]) nd++;
      run_op(1'b1, len, int'($urandom_range(100, 40)), -1, 0, -1, 1'b0, nd);
      check("rand_verify_chain_kept", chain & chain_mask(len), snap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
